mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 4, number of consecutive data grants allowed while an instruction request waits (range 1..15).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_req  in  1  instruction-fetch request.
- i_addr  in  32  fetch byte address; word access only.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  instruction response valid, one-cycle pulse.
- i_rdata  out  32  fetched word.
- i_fault  out  2  {access_fault, addr_misaligned} for the fetch.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_unit  in  2  00 byte, 01 half, 10 word.
- d_addr  in  32  data byte address.
- d_wd  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid, one-cycle pulse.
- d_rdata  out  32  load data; 0 for stores.
- d_fault  out  2  {access_fault, addr_misaligned}.
- m_re, m_we  out  1 each  bus read and write enables.
- m_rd_unit, m_wd_unit  out  2 each  bus access units.
- m_addr, m_wd  out  32 each  bus address and write data.
- m_rd  in  32  bus read data, combinational from the bus.
- m_access_fault, m_addr_misaligned  in  1 each  bus fault flags, combinational.

Function
REQ-003 SHALL implement the FSM states IDLE, BUS and RESP, with transitions IDLE->BUS on any grant, BUS->RESP always, and RESP->IDLE always.
REQ-004 SHALL assert at most one of i_gnt/d_gnt, and only in IDLE when the matching req is 1; all other cycles keep both at 0.
REQ-005 SHALL grant d_req over i_req, except when starve_cnt >= STARVE_LIMIT with i_req=1, which forces i_gnt.
REQ-006 SHALL keep a 4-bit starve_cnt: +1 (saturating at 15) on a d_gnt while i_req=1; cleared on i_gnt; cleared on a d_gnt while i_req=0.
REQ-007 SHALL register the granted command (source, we, unit, addr, wd) on the grant edge; requester inputs are don't-care after the grant.
REQ-008 SHALL drive the bus only in BUS: m_addr/m_wd from the command register; m_re=~we; m_we=we; m_rd_unit=m_wd_unit=unit; instruction commands force unit=10 and we=0.
REQ-009 SHALL drive m_re=m_we=0, m_addr=0, m_wd=0 and units=10 outside BUS.
REQ-010 SHALL capture m_rd, m_access_fault and m_addr_misaligned into response registers at the end of BUS.
REQ-011 SHALL pulse the owning source's rvalid for exactly one cycle in RESP, with rdata/fault from the response registers; a store returns rdata=0.
REQ-012 SHALL hold i_rdata/d_rdata/faults stable outside RESP at their last values; they are only meaningful with rvalid.
REQ-013 SHALL give grant-to-rvalid latency = 2 cycles and peak throughput = one access per 3 cycles.
REQ-014 SHALL accept a new grant in the IDLE cycle immediately after RESP (no bubble beyond RESP).
REQ-015 SHALL let a request that drops before its grant be forgotten, without changing starve_cnt.
REQ-016 SHALL pass faulted accesses through unchanged and not retry them; the faults are reported only via *_fault.

Reset
REQ-017 SHALL, when rst_n=0 on a clock edge, enter IDLE and clear starve_cnt, the command registers, the response registers, all rvalid, all gnt and all m_* outputs to 0 (units to 10).
REQ-018 SHALL, when reset occurs in BUS or RESP, drop the in-flight access with no rvalid pulse.

Verification
REQ-019 SHALL cover: single fetch i_addr=0x100, m_rd=0xDEADBEEF -> i_gnt at cycle 0, m_re=1 with m_addr=0x100 at cycle 1, i_rvalid=1 with i_rdata=0xDEADBEEF at cycle 2.
REQ-020 SHALL cover: i_req and d_req both held high with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-021 SHALL cover: store byte d_addr=0x203, d_wd=0xAB -> m_we=1, m_wd_unit=00, m_addr=0x203 in BUS; d_rvalid=1, d_rdata=0, d_fault=00.
REQ-022 SHALL cover: load with m_access_fault=1 in BUS -> d_rvalid=1, d_fault=10, no retry; the next IDLE grants the next pending request.
REQ-023 SHALL cover: rst_n=0 during BUS -> no rvalid in the following cycles; after release, the FSM is in IDLE with starve_cnt=0.
REQ-024 SHALL cover: i_req pulsed for one cycle while the arbiter is in BUS -> no i_gnt and no i_rvalid.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Instruction/data requester ports and memory-bus port of the memory arbiter.
// Latency: none, signal bundle only.
// Backpressure: requesters hold req until they see gnt; the bus side has no stall.
interface mem_arbiter_if;
  // instruction-fetch requester
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [1:0]  i_fault;
  // data requester
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_unit;
  logic [31:0] d_addr;
  logic [31:0] d_wd;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [1:0]  d_fault;
  // memory bus
  logic        m_re;
  logic        m_we;
  logic [1:0]  m_rd_unit;
  logic [1:0]  m_wd_unit;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [31:0] m_rd;
  logic        m_access_fault;
  logic        m_addr_misaligned;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_unit, d_addr, d_wd,
           m_rd, m_access_fault, m_addr_misaligned,
    output i_gnt, i_rvalid, i_rdata, i_fault,
           d_gnt, d_rvalid, d_rdata, d_fault,
           m_re, m_we, m_rd_unit, m_wd_unit, m_addr, m_wd
  );

  // requester/bus-model side
  modport master (
    output i_req, i_addr, d_req, d_we, d_unit, d_addr, d_wd,
           m_rd, m_access_fault, m_addr_misaligned,
    input  i_gnt, i_rvalid, i_rdata, i_fault,
           d_gnt, d_rvalid, d_rdata, d_fault,
           m_re, m_we, m_rd_unit, m_wd_unit, m_addr, m_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory bus, data-first with anti-starvation.
// Latency: grant cycle -> bus cycle -> rvalid cycle (2 cycles grant-to-rvalid, 1 access per 3 cycles).
// Backpressure: grants only in IDLE; a requester keeps req high until granted, dropped reqs are forgotten.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [1:0] UNIT_WORD = 2'b10;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;

  // command captured at grant; src_q = 1 means data requester owns the access
  logic        src_q;
  logic        we_q;
  logic [1:0]  unit_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;

  // per-source response registers, hold their last value between responses
  logic [31:0] i_rdata_q, d_rdata_q;
  logic [1:0]  i_fault_q, d_fault_q;

  logic        i_gnt_c, d_gnt_c, force_i;

  assign force_i = bus.i_req && (starve_q >= LIMIT);

  // state register and starvation counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // next state: any grant starts an access, BUS and RESP always advance
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_gnt_c || d_gnt_c) state_d = BUS;
      BUS:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: grants in IDLE, bus drive in BUS, rvalid pulse in RESP
  always_comb begin
    i_gnt_c         = 1'b0;
    d_gnt_c         = 1'b0;
    bus.m_re        = 1'b0;
    bus.m_we        = 1'b0;
    bus.m_rd_unit   = UNIT_WORD;
    bus.m_wd_unit   = UNIT_WORD;
    bus.m_addr      = '0;
    bus.m_wd        = '0;
    bus.i_rvalid    = 1'b0;
    bus.d_rvalid    = 1'b0;
    case (state_q)
      IDLE: begin
        // gated by rst_n so nothing is accepted on a reset edge
        if (rst_n) begin
          if (force_i)         i_gnt_c = 1'b1;
          else if (bus.d_req)  d_gnt_c = 1'b1;
          else if (bus.i_req)  i_gnt_c = 1'b1;
        end
      end
      BUS: begin
        bus.m_re      = ~we_q;
        bus.m_we      = we_q;
        bus.m_rd_unit = unit_q;
        bus.m_wd_unit = unit_q;
        bus.m_addr    = addr_q;
        bus.m_wd      = wd_q;
      end
      RESP: begin
        bus.i_rvalid = ~src_q;
        bus.d_rvalid = src_q;
      end
      default: ;
    endcase
  end

  assign bus.i_gnt   = i_gnt_c;
  assign bus.d_gnt   = d_gnt_c;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_fault = i_fault_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_fault = d_fault_q;

  // starvation count: data wins while fetch waits bump it, everything else clears it
  always_comb begin
    starve_d = starve_q;
    if (i_gnt_c) begin
      starve_d = 4'd0;
    end else if (d_gnt_c) begin
      if (bus.i_req) starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
      else           starve_d = 4'd0;
    end
  end

  // capture the granted command; fetches are always word reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q  <= 1'b0;
      we_q   <= 1'b0;
      unit_q <= UNIT_WORD;
      addr_q <= '0;
      wd_q   <= '0;
    end else if (d_gnt_c) begin
      src_q  <= 1'b1;
      we_q   <= bus.d_we;
      unit_q <= bus.d_unit;
      addr_q <= bus.d_addr;
      wd_q   <= bus.d_wd;
    end else if (i_gnt_c) begin
      src_q  <= 1'b0;
      we_q   <= 1'b0;
      unit_q <= UNIT_WORD;
      addr_q <= bus.i_addr;
      wd_q   <= '0;
    end
  end

  // latch bus response at the end of BUS into the owner's registers; stores read back 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      i_fault_q <= 2'b00;
      d_rdata_q <= '0;
      d_fault_q <= 2'b00;
    end else if (state_q == BUS) begin
      if (src_q) begin
        d_rdata_q <= we_q ? 32'd0 : bus.m_rd;
        d_fault_q <= {bus.m_access_fault, bus.m_addr_misaligned};
      end else begin
        i_rdata_q <= bus.m_rd;
        i_fault_q <= {bus.m_access_fault, bus.m_addr_misaligned};
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grant order, bus commands and responses.
// Latency: checks grant->bus = 1 and grant->rvalid = 2 cycles on every access.
// Backpressure: requests are held until granted, then dropped by the stimulus.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed { logic src; logic [7:0] gap; } gnt_t;
  typedef struct packed { logic we; logic [1:0] unit; logic [31:0] addr; logic [31:0] wd; } bus_t;
  typedef struct packed { logic src; logic [31:0] rdata; logic [1:0] fault; } rsp_t;

  gnt_t gnt_q[$];
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_gnt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input logic src, input logic [7:0] gap);
    gnt_q.push_back('{src: src, gap: gap});
  endtask

  task automatic exp_bus(input logic we, input logic [1:0] unit, input logic [31:0] addr, input logic [31:0] wd);
    bus_q.push_back('{we: we, unit: unit, addr: addr, wd: wd});
  endtask

  task automatic exp_rsp(input logic src, input logic [31:0] rdata, input logic [1:0] fault);
    rsp_q.push_back('{src: src, rdata: rdata, fault: fault});
  endtask

  // grant monitor: source order, one-hot, spacing between back-to-back grants
  always @(negedge clk) begin
    gnt_t g;
    if (bus.i_gnt || bus.d_gnt) begin
      chk("gnt_onehot", 64'(bus.i_gnt & bus.d_gnt), 64'd0);
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", 64'({bus.i_gnt, bus.d_gnt}), 64'd0);
      end else begin
        g = gnt_q.pop_front();
        chk("gnt_src", 64'({bus.i_gnt, bus.d_gnt}), g.src ? 64'd1 : 64'd2);
        if (g.gap != 8'd0) chk("gnt_gap", 64'(cyc - last_gnt_cyc), 64'(g.gap));
      end
      last_gnt_cyc = cyc;
    end
  end

  // bus monitor: command contents and one cycle after grant
  always @(negedge clk) begin
    bus_t b;
    if (bus.m_re || bus.m_we) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 64'({bus.m_re, bus.m_we}), 64'd0);
      end else begin
        b = bus_q.pop_front();
        chk("bus_ctl", 64'({bus.m_we, bus.m_re, bus.m_rd_unit, bus.m_wd_unit}),
            64'({b.we, ~b.we, b.unit, b.unit}));
        chk("bus_addr", 64'(bus.m_addr), 64'(b.addr));
        chk("bus_wd", 64'(bus.m_wd), 64'(b.wd));
        chk("bus_lat", 64'(cyc - last_gnt_cyc), 64'd1);
      end
    end
  end

  // response monitor: owner, data, faults and two cycles after grant
  always @(negedge clk) begin
    rsp_t r;
    if (bus.i_rvalid || bus.d_rvalid) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_src", 64'({bus.i_rvalid, bus.d_rvalid}), r.src ? 64'd1 : 64'd2);
        chk("rsp_rdata", 64'(r.src ? bus.d_rdata : bus.i_rdata), 64'(r.rdata));
        chk("rsp_fault", 64'(r.src ? bus.d_fault : bus.i_fault), 64'(r.fault));
        chk("rsp_lat", 64'(cyc - last_gnt_cyc), 64'd2);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_unit = 2'b10; bus.d_addr = '0; bus.d_wd = '0;
    bus.m_rd = '0; bus.m_access_fault = 1'b0; bus.m_addr_misaligned = 1'b0;

    // reset: requests present but nothing granted, bus idle
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick(2);
    chk("rst_gnt", 64'({bus.i_gnt, bus.d_gnt}), 64'd0);
    chk("rst_bus_ctl", 64'({bus.m_re, bus.m_we, bus.m_rd_unit, bus.m_wd_unit}), 64'b001010);
    chk("rst_bus_addr", 64'({bus.m_addr, bus.m_wd}), 64'd0);
    chk("rst_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
    chk("rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'd0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    rst_n = 1'b1;
    tick(2);

    // single fetch
    bus.m_rd = 32'hDEADBEEF;
    exp_gnt(1'b0, 8'd0); exp_bus(1'b0, 2'b10, 32'h100, 32'd0); exp_rsp(1'b0, 32'hDEADBEEF, 2'b00);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    tick(1); bus.i_req = 1'b0;
    tick(4);
    chk("i_rdata_hold", 64'(bus.i_rdata), 64'h DEADBEEF);

    // byte store returns rdata 0 regardless of bus read data
    bus.m_rd = 32'hCAFEF00D;
    exp_gnt(1'b1, 8'd0); exp_bus(1'b1, 2'b00, 32'h203, 32'hAB); exp_rsp(1'b1, 32'd0, 2'b00);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_unit = 2'b00; bus.d_addr = 32'h203; bus.d_wd = 32'hAB;
    tick(1); bus.d_req = 1'b0;
    tick(4);

    // faulted load passes through, pending fetch granted next IDLE
    bus.m_rd = 32'h0BADF00D; bus.m_access_fault = 1'b1;
    exp_gnt(1'b1, 8'd0); exp_bus(1'b0, 2'b10, 32'h300, 32'd0); exp_rsp(1'b1, 32'h0BADF00D, 2'b10);
    exp_gnt(1'b0, 8'd3); exp_bus(1'b0, 2'b10, 32'h104, 32'd0); exp_rsp(1'b0, 32'h0BADF00D, 2'b00);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_unit = 2'b10; bus.d_addr = 32'h300; bus.d_wd = 32'd0;
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    tick(1); bus.d_req = 1'b0;
    tick(1); bus.m_access_fault = 1'b0;
    tick(2); bus.i_req = 1'b0;
    tick(4);

    // misaligned fetch reported on i_fault
    bus.m_rd = 32'h11112222; bus.m_addr_misaligned = 1'b1;
    exp_gnt(1'b0, 8'd0); exp_bus(1'b0, 2'b10, 32'h102, 32'd0); exp_rsp(1'b0, 32'h11112222, 2'b01);
    bus.i_req = 1'b1; bus.i_addr = 32'h102;
    tick(1); bus.i_req = 1'b0;
    tick(4); bus.m_addr_misaligned = 1'b0;

    // both requesting: D,D,D,D,I twice, back-to-back every 3 cycles
    bus.m_rd = 32'h12345678;
    for (int k = 0; k < 10; k++) begin
      logic is_i;
      is_i = (k == 4) || (k == 9);
      exp_gnt(~is_i, (k == 0) ? 8'd0 : 8'd3);
      if (is_i) begin
        exp_bus(1'b0, 2'b10, 32'h400, 32'd0); exp_rsp(1'b0, 32'h12345678, 2'b00);
      end else begin
        exp_bus(1'b0, 2'b01, 32'h802, 32'd0); exp_rsp(1'b1, 32'h12345678, 2'b00);
      end
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_unit = 2'b01; bus.d_addr = 32'h802; bus.d_wd = 32'd0;
    tick(28); bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick(4);

    // reset during BUS of 4th data access: no response, starve count cleared
    for (int k = 0; k < 4; k++) begin
      exp_gnt(1'b1, (k == 0) ? 8'd0 : 8'd3);
      exp_bus(1'b0, 2'b01, 32'h802, 32'd0);
      if (k < 3) exp_rsp(1'b1, 32'h12345678, 2'b00);
    end
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick(10);
    rst_n = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick(1);
    chk("rst_busy_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
    chk("rst_busy_bus", 64'({bus.m_re, bus.m_we, bus.m_rd_unit, bus.m_wd_unit}), 64'b001010);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      exp_gnt(k != 4, (k == 0) ? 8'd0 : 8'd3);
      if (k == 4) begin
        exp_bus(1'b0, 2'b10, 32'h400, 32'd0); exp_rsp(1'b0, 32'h12345678, 2'b00);
      end else begin
        exp_bus(1'b0, 2'b01, 32'h802, 32'd0); exp_rsp(1'b1, 32'h12345678, 2'b00);
      end
    end
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick(13); bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick(4);

    // fetch pulsed only during BUS is never granted
    bus.m_rd = 32'hA5A5A5A5;
    exp_gnt(1'b1, 8'd0); exp_bus(1'b0, 2'b10, 32'h900, 32'd0); exp_rsp(1'b1, 32'hA5A5A5A5, 2'b00);
    bus.d_req = 1'b1; bus.d_unit = 2'b10; bus.d_addr = 32'h900;
    tick(1); bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h500;
    tick(1); bus.i_req = 1'b0;
    tick(5);

    chk("gnt_q_left", 64'(gnt_q.size()), 64'd0);
    chk("bus_q_left", 64'(bus_q.size()), 64'd0);
    chk("rsp_q_left", 64'(rsp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
